// File: rtl/led_effect_engine_pkg.sv
// Shared encodings for the LED effect engine: modes, FSM states, colour-wheel constants
// and the per-LED fade scaling helper.
package led_effect_engine_pkg;

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_STATIC  = 2'b01;
  localparam logic [1:0] MODE_FADE    = 2'b10;
  localparam logic [1:0] MODE_RAINBOW = 2'b11;

  localparam logic [9:0] WHEEL_SEG1 = 10'd256;
  localparam logic [9:0] WHEEL_SEG2 = 10'd512;
  localparam logic [9:0] WHEEL_SPAN = 10'd768;
  localparam logic [9:0] WHEEL_HALF = 10'd384;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC0,
    ST_CALC1,
    ST_LATCH,
    ST_STROBE
  } state_e;

  // Scale one 8-bit channel by (lvl+1)/256; a zero level is forced fully dark.
  function automatic logic [7:0] fade_chan(input logic [7:0] c, input logic [7:0] lvl);
    logic [8:0]  scale;
    logic [15:0] prod;
    scale = {1'b0, lvl} + 9'd1;
    prod  = {8'd0, c} * {7'd0, scale};
    return (lvl == 8'd0) ? 8'd0 : 8'(prod >> 8);
  endfunction

  function automatic logic [23:0] fade_rgb(input logic [23:0] c, input logic [7:0] lvl);
    return {fade_chan(c[23:16], lvl), fade_chan(c[15:8], lvl), fade_chan(c[7:0], lvl)};
  endfunction

endpackage

// File: rtl/led_effect_engine_color_wheel.sv
// Combinational hue (0..767) to {R,G,B} colour wheel; zero latency, no flow control.
module color_wheel
  import led_effect_engine_pkg::*;
(
  input  logic [9:0]  hue,
  output logic [23:0] rgb
);

  logic [7:0] s;
  assign s = hue[7:0];

  always_comb begin
    rgb = '0;
    if (hue < WHEEL_SEG1) begin
      rgb = {8'd255 - s, s, 8'd0};
    end else if (hue < WHEEL_SEG2) begin
      rgb = {8'd0, 8'd255 - s, s};
    end else begin
      rgb = {s, 8'd0, 8'd255 - s};
    end
  end

endmodule

// File: rtl/led_effect_engine.sv
// Frame-rate colour source for a two-pixel WS2812B chain: per frame computes both colours,
// latches them together and emits a one-cycle active-low start strobe one cycle later.
module led_effect_engine
  import led_effect_engine_pkg::*;
#(
  parameter int SYS_FREQ  = 12_090_000,
  parameter int FRAME_HZ  = 100,
  parameter int FADE_STEP = 8,
  parameter int HUE_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  key_pulse,
  input  logic [1:0]  mode,
  input  logic [23:0] static_color,
  output logic [23:0] rgb_data_0,
  output logic [23:0] rgb_data_1,
  output logic        start_n,
  output logic        frame_tick
);

  localparam int FRAME_DIV = SYS_FREQ / FRAME_HZ;
  localparam int CW        = $clog2(FRAME_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_DIV - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(FRAME_DIV - 2);
  localparam logic [7:0]  FADE_DEC = 8'(FADE_STEP);
  localparam logic [10:0] HUE_INC  = 11'(HUE_STEP);

  state_e        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [9:0]    hue;
  logic [7:0]    intensity [2];
  logic [23:0]   hold0, hold1;
  logic [1:0]    mode_q;

  logic [10:0]   hue_opp_sum, hue_adv_sum;
  logic [9:0]    hue_opp, hue_adv, wheel_hue;
  logic [23:0]   wheel_rgb, calc_rgb;
  logic [1:0]    sel_mode;
  logic [7:0]    sel_int;

  // frame_tick is registered one count early so it is high exactly while cnt == FRAME_DIV-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      frame_tick <= (cnt == CNT_PRE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (frame_tick) state_nxt = ST_CALC0;
      ST_CALC0:  state_nxt = ST_CALC1;
      ST_CALC1:  state_nxt = ST_LATCH;
      ST_LATCH:  state_nxt = ST_STROBE;
      ST_STROBE: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    hue_opp_sum = {1'b0, hue} + {1'b0, WHEEL_HALF};
    hue_opp     = 10'((hue_opp_sum >= {1'b0, WHEEL_SPAN}) ? hue_opp_sum - {1'b0, WHEEL_SPAN}
                                                          : hue_opp_sum);
    hue_adv_sum = {1'b0, hue} + HUE_INC;
    hue_adv     = 10'((hue_adv_sum >= {1'b0, WHEEL_SPAN}) ? hue_adv_sum - {1'b0, WHEEL_SPAN}
                                                          : hue_adv_sum);
  end

  // One wheel serves both LEDs: CALC1 looks at the hue half a turn away.
  assign wheel_hue = (state == ST_CALC1) ? hue_opp : hue;

  color_wheel u_wheel (
    .hue (wheel_hue),
    .rgb (wheel_rgb)
  );

  always_comb begin
    sel_mode = (state == ST_CALC1) ? mode_q : mode;
    sel_int  = (state == ST_CALC1) ? intensity[1] : intensity[0];
    case (sel_mode)
      MODE_OFF:    calc_rgb = '0;
      MODE_STATIC: calc_rgb = static_color;
      MODE_FADE:   calc_rgb = fade_rgb(static_color, sel_int);
      default:     calc_rgb = wheel_rgb;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold0      <= '0;
      hold1      <= '0;
      mode_q     <= MODE_OFF;
      rgb_data_0 <= '0;
      rgb_data_1 <= '0;
      hue        <= '0;
      start_n    <= 1'b1;
    end else begin
      start_n <= (state != ST_STROBE);
      if (state == ST_CALC0) begin
        hold0  <= calc_rgb;
        mode_q <= mode;
      end
      if (state == ST_CALC1) hold1 <= calc_rgb;
      if (state == ST_LATCH) begin
        rgb_data_0 <= hold0;
        rgb_data_1 <= hold1;
        if (mode == MODE_RAINBOW) hue <= hue_adv;
      end
    end
  end

  // A key press overrides the per-frame decay when both land on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) intensity[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (key_pulse[i]) begin
          intensity[i] <= 8'd255;
        end else if (state == ST_LATCH) begin
          intensity[i] <= (intensity[i] > FADE_DEC) ? intensity[i] - FADE_DEC : 8'd0;
        end
      end
    end
  end

endmodule
